// File: rtl/debug_trace_if.sv
// Configuration bus for debug_trace: per-channel select/mode/stretch plus update and clear strobes.
// Master drives the fields; the trace block samples them on cfg_update.
interface debug_trace_if #(
  parameter int N_GPIO    = 4,
  parameter int STRETCH_W = 16
);
  logic [N_GPIO-1:0][7:0]           cfg_type;
  logic [N_GPIO-1:0][55:0]          cfg_value;
  logic [N_GPIO-1:0][1:0]           cfg_mode;
  logic [N_GPIO-1:0][STRETCH_W-1:0] cfg_stretch;
  logic                             cfg_update;
  logic                             clear;

  modport master (
    output cfg_type, cfg_value, cfg_mode, cfg_stretch, cfg_update, clear
  );

  modport slave (
    input cfg_type, cfg_value, cfg_mode, cfg_stretch, cfg_update, clear
  );
endinterface

// File: rtl/debug_trace.sv
// Debug GPIO generator: per channel, select an internal signal and shape it (level/pulse/toggle/latch).
// Latency 2 cycles input->pin; no backpressure, status inputs are sampled every cycle.
module debug_trace #(
  parameter int DEPTH     = 249,
  parameter int N_GPIO    = 4,
  parameter int STRETCH_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  debug_trace_if.slave      i_cfg,
  input  logic [7:0]        i_time_cnt,
  input  logic [55:0]       i_sys_time,
  input  logic [DEPTH-1:0]  i_pwm_out,
  input  logic              i_thermo,
  input  logic              i_force_fan,
  input  logic              i_sync,
  input  logic              i_stm_segment,
  input  logic              i_mod_segment,
  input  logic [12:0]       i_stm_idx,
  input  logic [14:0]       i_mod_idx,
  input  logic [12:0]       i_stm_cycle,
  output logic [N_GPIO-1:0] o_gpio_out
);

  localparam logic [7:0] DBG_NONE        = 8'h00;
  localparam logic [7:0] DBG_BASE_SIG    = 8'h01;
  localparam logic [7:0] DBG_THERMO      = 8'h02;
  localparam logic [7:0] DBG_FORCE_FAN   = 8'h03;
  localparam logic [7:0] DBG_SYNC        = 8'h10;
  localparam logic [7:0] DBG_MOD_SEGMENT = 8'h20;
  localparam logic [7:0] DBG_MOD_IDX     = 8'h21;
  localparam logic [7:0] DBG_STM_SEGMENT = 8'h50;
  localparam logic [7:0] DBG_STM_IDX     = 8'h51;
  localparam logic [7:0] DBG_IS_STM_MODE = 8'h52;
  localparam logic [7:0] DBG_SYS_TIME_EQ = 8'h60;
  localparam logic [7:0] DBG_PWM_OUT     = 8'hE0;
  localparam logic [7:0] DBG_DIRECT      = 8'hF0;

  localparam logic [1:0] MODE_LEVEL  = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_TOGGLE = 2'd2;
  localparam logic [1:0] MODE_LATCH  = 2'd3;

  // Zero-extended so an out-of-range PWM index can never select a real output.
  logic [255:0] w_pwm_ext;
  logic         w_unused;
  assign w_pwm_ext = 256'(i_pwm_out);
  assign w_unused  = ^{i_sys_time[7:0], i_time_cnt[6:0]};

  for (genvar g = 0; g < N_GPIO; g++) begin : g_ch
    logic [7:0]           r_type;
    logic [55:0]          r_value;
    logic [1:0]           r_mode;
    logic [STRETCH_W-1:0] r_stretch;
    logic [STRETCH_W-1:0] r_cnt;
    logic                 r_raw, r_prev, r_raw_vld, r_armed;
    logic                 r_tog, r_latch, r_out;

    logic                 w_raw, w_rise;
    logic [STRETCH_W-1:0] w_cnt_nxt;
    logic                 w_pulse_nxt, w_tog_nxt, w_latch_nxt, w_out_nxt;

    always_comb begin
      w_raw = 1'b0;
      case (r_type)
        DBG_NONE:        w_raw = 1'b0;
        DBG_BASE_SIG:    w_raw = ~i_time_cnt[7];
        DBG_THERMO:      w_raw = i_thermo;
        DBG_FORCE_FAN:   w_raw = i_force_fan;
        DBG_SYNC:        w_raw = i_sync;
        DBG_MOD_SEGMENT: w_raw = i_mod_segment;
        DBG_STM_SEGMENT: w_raw = i_stm_segment;
        DBG_MOD_IDX:     w_raw = (i_mod_idx == r_value[14:0]);
        DBG_STM_IDX:     w_raw = (i_stm_idx == r_value[12:0]);
        DBG_IS_STM_MODE: w_raw = (i_stm_cycle != 13'd0);
        DBG_SYS_TIME_EQ: w_raw = (i_sys_time[55:8] == r_value[55:8]);
        DBG_PWM_OUT:     w_raw = (int'(r_value[7:0]) < DEPTH) ? w_pwm_ext[r_value[7:0]] : 1'b0;
        DBG_DIRECT:      w_raw = r_value[0];
        default:         w_raw = 1'b0;
      endcase
    end

    // r_armed stays low through the first cycle that r_raw holds a real sample.
    always_comb begin
      w_rise      = r_armed & r_raw & ~r_prev;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      w_tog_nxt   = r_tog;
      w_latch_nxt = r_latch;

      if (w_rise) begin
        w_cnt_nxt   = r_stretch;
        w_pulse_nxt = 1'b1;
      end else if (i_cfg.clear) begin
        w_cnt_nxt   = '0;
      end else if (r_cnt != '0) begin
        w_cnt_nxt   = r_cnt - STRETCH_W'(1);
        w_pulse_nxt = 1'b1;
      end

      if (w_rise)           w_tog_nxt = i_cfg.clear ? 1'b1 : ~r_tog;
      else if (i_cfg.clear) w_tog_nxt = 1'b0;

      if (w_rise)           w_latch_nxt = 1'b1;
      else if (i_cfg.clear) w_latch_nxt = 1'b0;

      case (r_mode)
        MODE_LEVEL:  w_out_nxt = r_raw;
        MODE_PULSE:  w_out_nxt = w_pulse_nxt;
        MODE_TOGGLE: w_out_nxt = w_tog_nxt;
        MODE_LATCH:  w_out_nxt = w_latch_nxt;
        default:     w_out_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_type    <= DBG_NONE;
        r_value   <= '0;
        r_mode    <= MODE_LEVEL;
        r_stretch <= '0;
        r_cnt     <= '0;
        r_raw     <= 1'b0;
        r_prev    <= 1'b0;
        r_raw_vld <= 1'b0;
        r_armed   <= 1'b0;
        r_tog     <= 1'b0;
        r_latch   <= 1'b0;
        r_out     <= 1'b0;
      end else if (i_cfg.cfg_update) begin
        r_type    <= i_cfg.cfg_type[g];
        r_value   <= i_cfg.cfg_value[g];
        r_mode    <= i_cfg.cfg_mode[g];
        r_stretch <= i_cfg.cfg_stretch[g];
        r_cnt     <= '0;
        r_raw     <= 1'b0;
        r_prev    <= 1'b0;
        r_raw_vld <= 1'b0;
        r_armed   <= 1'b0;
        r_tog     <= 1'b0;
        r_latch   <= 1'b0;
        r_out     <= 1'b0;
      end else begin
        r_raw     <= w_raw;
        r_prev    <= r_raw;
        r_raw_vld <= 1'b1;
        r_armed   <= r_raw_vld;
        r_cnt     <= w_cnt_nxt;
        r_tog     <= w_tog_nxt;
        r_latch   <= w_latch_nxt;
        r_out     <= w_out_nxt;
      end
    end

    assign o_gpio_out[g] = r_out;
  end

endmodule

// File: tb/tb_debug_trace.sv
// Directed bench for debug_trace: inputs driven and outputs sampled on the falling clock edge.
module tb_debug_trace;
  localparam int DEPTH = 249;
  localparam int N_GPIO = 4;
  localparam int SW = 16;

  localparam logic [7:0] DBG_BASE_SIG    = 8'h01;
  localparam logic [7:0] DBG_THERMO      = 8'h02;
  localparam logic [7:0] DBG_FORCE_FAN   = 8'h03;
  localparam logic [7:0] DBG_SYNC        = 8'h10;
  localparam logic [7:0] DBG_MOD_SEGMENT = 8'h20;
  localparam logic [7:0] DBG_MOD_IDX     = 8'h21;
  localparam logic [7:0] DBG_STM_SEGMENT = 8'h50;
  localparam logic [7:0] DBG_STM_IDX     = 8'h51;
  localparam logic [7:0] DBG_IS_STM_MODE = 8'h52;
  localparam logic [7:0] DBG_SYS_TIME_EQ = 8'h60;
  localparam logic [7:0] DBG_PWM_OUT     = 8'hE0;
  localparam logic [7:0] DBG_DIRECT      = 8'hF0;

  localparam logic [1:0] M_LEVEL  = 2'd0;
  localparam logic [1:0] M_PULSE  = 2'd1;
  localparam logic [1:0] M_TOGGLE = 2'd2;
  localparam logic [1:0] M_LATCH  = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [7:0]        time_cnt;
  logic [55:0]       sys_time;
  logic [DEPTH-1:0]  pwm;
  logic              thermo, force_fan, sync, stm_seg, mod_seg;
  logic [12:0]       stm_idx, stm_cycle;
  logic [14:0]       mod_idx;
  logic [N_GPIO-1:0] gpio;

  int total = 0;
  int bad   = 0;

  debug_trace_if #(.N_GPIO(N_GPIO), .STRETCH_W(SW)) cfg_if ();

  debug_trace #(.DEPTH(DEPTH), .N_GPIO(N_GPIO), .STRETCH_W(SW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg(cfg_if),
    .i_time_cnt(time_cnt), .i_sys_time(sys_time), .i_pwm_out(pwm),
    .i_thermo(thermo), .i_force_fan(force_fan), .i_sync(sync),
    .i_stm_segment(stm_seg), .i_mod_segment(mod_seg),
    .i_stm_idx(stm_idx), .i_mod_idx(mod_idx), .i_stm_cycle(stm_cycle),
    .o_gpio_out(gpio)
  );

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [7:0] t, input logic [55:0] v,
                        input logic [1:0] m, input logic [SW-1:0] s);
    cfg_if.cfg_type[ch]    = t;
    cfg_if.cfg_value[ch]   = v;
    cfg_if.cfg_mode[ch]    = m;
    cfg_if.cfg_stretch[ch] = s;
  endtask

  task automatic update();
    cfg_if.cfg_update = 1'b1;
    step();
    cfg_if.cfg_update = 1'b0;
  endtask

  task automatic pulse_clear();
    cfg_if.clear = 1'b1;
    step();
    cfg_if.clear = 1'b0;
  endtask

  task automatic inputs_zero();
    time_cnt = '0; sys_time = '0; pwm = '0;
    thermo = 0; force_fan = 0; sync = 0; stm_seg = 0; mod_seg = 0;
    stm_idx = '0; stm_cycle = '0; mod_idx = '0;
  endtask

  task automatic test_reset();
    inputs_zero();
    cfg_if.cfg_type = '0; cfg_if.cfg_value = '0; cfg_if.cfg_mode = '0;
    cfg_if.cfg_stretch = '0; cfg_if.cfg_update = 1'b0; cfg_if.clear = 1'b0;
    rst_n = 1'b0;
    step(3);
    total++;
    if (gpio !== 4'b0000) begin bad++; $display("FAIL reset_out got=%b want=0000", gpio); end
    rst_n = 1'b1;
    step(3);
    total++;
    if (gpio !== 4'b0000) begin bad++; $display("FAIL post_reset_none got=%b want=0000", gpio); end
  endtask

  task automatic test_base_sig();
    logic [7:0] tc [10];
    logic       exp;
    tc = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h40, 8'hC0, 8'h81, 8'h01, 8'h90, 8'h10};
    set_ch(0, DBG_BASE_SIG, 56'd0, M_LEVEL, 16'd0);
    update();
    for (int i = 0; i < 10; i++) begin
      time_cnt = tc[i];
      step();
      exp = (i == 0) ? 1'b0 : ~tc[i-1][7];
      total++;
      if (gpio[0] !== exp) begin bad++; $display("FAIL base_sig step=%0d got=%b want=%b", i, gpio[0], exp); end
    end
    total++;
    if (gpio[3:1] !== 3'b000) begin bad++; $display("FAIL base_sig_others got=%b want=000", gpio[3:1]); end
    time_cnt = '0;
  endtask

  task automatic test_level_types();
    logic [7:0]  typ  [12];
    logic [55:0] val  [12];
    logic [55:0] sys  [12];
    logic [12:0] sidx [12];
    logic [12:0] scyc [12];
    logic [3:0]  flg  [12];
    logic        exp  [12];
    typ  = '{DBG_SYS_TIME_EQ, DBG_SYS_TIME_EQ, DBG_STM_IDX, DBG_STM_IDX, DBG_IS_STM_MODE, DBG_IS_STM_MODE,
             DBG_DIRECT, DBG_DIRECT, DBG_FORCE_FAN, DBG_MOD_SEGMENT, DBG_STM_SEGMENT, DBG_THERMO};
    val  = '{56'h12_3456_789A_BC00, 56'h12_3456_789A_BC00, 56'h0ABC, 56'h0ABC, 56'd0, 56'd0,
             56'd1, 56'd2, 56'd0, 56'd0, 56'd0, 56'd0};
    sys  = '{56'h12_3456_789A_BCFF, 56'h12_3456_789A_BD00, 56'd0, 56'd0, 56'd0, 56'd0,
             56'd0, 56'd0, 56'd0, 56'd0, 56'd0, 56'd0};
    sidx = '{13'd0, 13'd0, 13'h0ABC, 13'h0ABD, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
    scyc = '{13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'h1000, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0, 13'd0};
    // flg = {thermo, force_fan, mod_segment, stm_segment}
    flg  = '{4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0010, 4'b0001, 4'b0001};
    exp  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      sys_time = sys[i]; stm_idx = sidx[i]; stm_cycle = scyc[i];
      {thermo, force_fan, mod_seg, stm_seg} = flg[i];
      set_ch(0, typ[i], val[i], M_LEVEL, 16'd0);
      update();
      step(3);
      total++;
      if (gpio[0] !== exp[i]) begin bad++; $display("FAIL level_type row=%0d type=%h got=%b want=%b", i, typ[i], gpio[0], exp[i]); end
    end
    inputs_zero();
  endtask

  task automatic test_pulse();
    logic [11:0] stim, obs;
    thermo = 1'b0;
    set_ch(1, DBG_THERMO, 56'd0, M_PULSE, 16'd3);
    update();
    step(4);
    stim = 12'hFFF;
    for (int j = 0; j < 12; j++) begin thermo = stim[j]; step(); obs[j] = gpio[1]; end
    total++;
    if (obs !== 12'b0000_0001_1110) begin bad++; $display("FAIL pulse_s3 got=%b want=000000011110", obs); end
    thermo = 1'b0;
    step(6);
    stim = 12'hFFD;
    for (int j = 0; j < 12; j++) begin thermo = stim[j]; step(); obs[j] = gpio[1]; end
    total++;
    if (obs !== 12'b0000_0111_1110) begin bad++; $display("FAIL pulse_retrigger got=%b want=000001111110", obs); end
    thermo = 1'b0;
    set_ch(1, DBG_THERMO, 56'd0, M_PULSE, 16'd0);
    update();
    step(4);
    stim = 12'hFFF;
    for (int j = 0; j < 12; j++) begin thermo = stim[j]; step(); obs[j] = gpio[1]; end
    total++;
    if (obs !== 12'b0000_0000_0010) begin bad++; $display("FAIL pulse_s0 got=%b want=000000000010", obs); end
    thermo = 1'b0;
  endtask

  task automatic test_toggle();
    logic [3:0] want [4];
    want = '{4'd1, 4'd0, 4'd1, 4'd1};
    mod_idx = '0;
    set_ch(0, DBG_DIRECT, 56'd1, M_LEVEL, 16'd0);
    set_ch(2, DBG_MOD_IDX, 56'h0005, M_TOGGLE, 16'd0);
    update();
    step(4);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 10; k++) begin mod_idx = 15'(k); step(); end
      step(2);
      total++;
      if (gpio[2] !== want[p][0]) begin bad++; $display("FAIL toggle_pass%0d got=%b want=%b", p, gpio[2], want[p][0]); end
      if (p == 2) begin
        pulse_clear();
        step(2);
        total++;
        if (gpio[2] !== 1'b0) begin bad++; $display("FAIL toggle_clear got=%b want=0", gpio[2]); end
        total++;
        if (gpio[0] !== 1'b1) begin bad++; $display("FAIL level_ignores_clear got=%b want=1", gpio[0]); end
      end
    end
    mod_idx = 15'd5;
    step();
    mod_idx = 15'd6;
    cfg_if.clear = 1'b1;
    step();
    cfg_if.clear = 1'b0;
    step(2);
    total++;
    if (gpio[2] !== 1'b1) begin bad++; $display("FAIL toggle_clear_rise got=%b want=1", gpio[2]); end
    mod_idx = '0;
  endtask

  task automatic test_latch();
    pwm = '0;
    set_ch(3, DBG_PWM_OUT, 56'd248, M_LATCH, 16'd0);
    update();
    step(4);
    total++;
    if (gpio[3] !== 1'b0) begin bad++; $display("FAIL latch_idle got=%b want=0", gpio[3]); end
    pwm[247] = 1'b1;
    step(3);
    total++;
    if (gpio[3] !== 1'b0) begin bad++; $display("FAIL latch_wrong_bit got=%b want=0", gpio[3]); end
    pwm[248] = 1'b1;
    step(3);
    total++;
    if (gpio[3] !== 1'b1) begin bad++; $display("FAIL latch_set got=%b want=1", gpio[3]); end
    pwm = '0;
    step(3);
    total++;
    if (gpio[3] !== 1'b1) begin bad++; $display("FAIL latch_hold got=%b want=1", gpio[3]); end
    pulse_clear();
    step(2);
    total++;
    if (gpio[3] !== 1'b0) begin bad++; $display("FAIL latch_clear got=%b want=0", gpio[3]); end
    set_ch(3, DBG_PWM_OUT, 56'd249, M_LATCH, 16'd0);
    update();
    step(4);
    pwm = '1;
    step(3);
    total++;
    if (gpio[3] !== 1'b0) begin bad++; $display("FAIL latch_out_of_range got=%b want=0", gpio[3]); end
    pwm = '0;
  endtask

  task automatic test_disarm_reset();
    sync = 1'b1;
    set_ch(0, DBG_SYNC, 56'd0, M_LATCH, 16'd0);
    update();
    step(5);
    total++;
    if (gpio[0] !== 1'b0) begin bad++; $display("FAIL disarm_sync_high got=%b want=0", gpio[0]); end
    sync = 1'b0;
    step(2);
    sync = 1'b1;
    step(3);
    total++;
    if (gpio[0] !== 1'b1) begin bad++; $display("FAIL sync_latch got=%b want=1", gpio[0]); end
    thermo = 1'b0;
    set_ch(1, DBG_THERMO, 56'd0, M_PULSE, 16'd10);
    update();
    step(4);
    thermo = 1'b1;
    step(3);
    total++;
    if (gpio[1] !== 1'b1) begin bad++; $display("FAIL pulse_active got=%b want=1", gpio[1]); end
    rst_n = 1'b0;
    step();
    total++;
    if (gpio !== 4'b0000) begin bad++; $display("FAIL reset_mid_pulse got=%b want=0000", gpio); end
    rst_n = 1'b1;
    step(3);
    total++;
    if (gpio !== 4'b0000) begin bad++; $display("FAIL reset_shadow_none got=%b want=0000", gpio); end
    thermo = 1'b0;
    sync = 1'b0;
  endtask

  task automatic test_unknown_and_upd_clear();
    for (int ch = 0; ch < N_GPIO; ch++) set_ch(ch, 8'hFF, 56'hFF_FFFF_FFFF_FFFF, 2'(ch), 16'd3);
    update();
    step(2);
    for (int r = 0; r < 3; r++) begin
      pwm = (r == 1) ? '0 : '1;
      {thermo, force_fan, sync, stm_seg, mod_seg} = (r == 1) ? 5'b0 : 5'b11111;
      stm_cycle = (r == 1) ? 13'd0 : 13'd7;
      step(3);
    end
    total++;
    if (gpio !== 4'b0000) begin bad++; $display("FAIL unknown_type got=%b want=0000", gpio); end
    inputs_zero();
    set_ch(2, DBG_SYNC, 56'd0, M_LATCH, 16'd0);
    update();
    step(4);
    sync = 1'b1;
    step(3);
    total++;
    if (gpio[2] !== 1'b1) begin bad++; $display("FAIL upd_clear_pre got=%b want=1", gpio[2]); end
    cfg_if.cfg_update = 1'b1;
    cfg_if.clear = 1'b1;
    step();
    cfg_if.cfg_update = 1'b0;
    cfg_if.clear = 1'b0;
    step(5);
    total++;
    if (gpio[2] !== 1'b0) begin bad++; $display("FAIL upd_clear_zeroed got=%b want=0", gpio[2]); end
    sync = 1'b0;
    step(2);
    sync = 1'b1;
    step(3);
    total++;
    if (gpio[2] !== 1'b1) begin bad++; $display("FAIL upd_clear_relatch got=%b want=1", gpio[2]); end
    inputs_zero();
  endtask

  initial begin
    test_reset();
    test_base_sig();
    test_level_types();
    test_pulse();
    test_toggle();
    test_latch();
    test_disarm_reset();
    test_unknown_and_upd_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
